word_byte_serializer: RTL and testbench



---
 rtl/ser_pkg.sv | 32 +++
 rtl/word_byte_serializer.sv | 148 ++++++++++++++
 tb/tb_word_byte_serializer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types, constants and byte-select helper for word_byte_serializer
//
// Purpose: constants and types shared by the serializer RTL.
//   BYTES_PER_WORD / BYTE_W : word geometry (4 bytes of 8 bits)
//   ser_state_t             : serializer FSM states
//   byte_idx_t              : byte position within a word
//   byte_sel()              : pick byte idx of a word in LSB-first or MSB-first order
package ser_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  typedef logic [1:0] byte_idx_t;

  localparam byte_idx_t LAST_IDX = byte_idx_t'(BYTES_PER_WORD - 1);

  // idx is the transmit slot (0 = first byte sent); msb_first mirrors it
  // so slot 0 maps onto bits 31:24 instead of bits 7:0.
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [31:0] word,
                                                 input byte_idx_t   idx,
                                                 input logic        msb_first);
    byte_idx_t pos;
    pos = msb_first ? (LAST_IDX - idx) : idx;
    return word[{pos, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// rtl/word_byte_serializer.sv - 32-bit word to valid/ready byte stream serializer
//
// Purpose: accepts one word per in_valid/in_ready handshake and emits it as
// four bytes on a valid/ready byte stream, with back-to-back words carrying
// no bubble when the sink never stalls.
//
// Parameters:
//   MSB_FIRST : 0 = bits 7:0 sent first, 1 = bits 31:24 sent first
//   WORD_W    : input word width, fixed at 32
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   clear      in   synchronous abort, drops any word in progress
//   in_valid   in   upstream word valid
//   in_ready   out  word can be accepted this cycle (combinational)
//   in_data    in   upstream word
//   out_valid  out  out_byte valid
//   out_ready  in   byte sink accepts this cycle
//   out_byte   out  current byte (registered)
//   out_last   out  high with the 4th byte of a word
//   busy       out  a word is held
//   out_parity out  XOR of out_byte, registered with it
//                   (present only when SERIALIZER_PARITY_EN is defined)
//
// Build option: define SERIALIZER_PARITY_EN to add out_parity.
module word_byte_serializer
  import ser_pkg::*;
#(
  parameter int MSB_FIRST = 0,
  parameter int WORD_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_byte,
  output logic              out_last,
  output logic              busy
`ifdef SERIALIZER_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  localparam logic MSB = (MSB_FIRST != 0);

  ser_state_t       state;
  ser_state_t       next_state;
  byte_idx_t        cnt;
  logic [WORD_W-1:0] shreg;

  logic at_last;
  logic accept;
  logic xfer;

  assign at_last = (cnt == LAST_IDX);
  assign accept  = in_valid && in_ready;
  assign xfer    = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; clear wins over any handshake
  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) next_state = SHIFT;
        end
        SHIFT: begin
          // A reload on the last byte keeps us in SHIFT with no bubble.
          if (xfer && at_last && !accept) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out_last  = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !clear;
      end
      SHIFT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = at_last;
        in_ready  = !clear && at_last && out_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Datapath: word store, byte counter, registered output byte.
  // out_byte is loaded one slot ahead so the next byte is ready the cycle
  // after each transfer; it simply holds while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      cnt      <= '0;
      out_byte <= '0;
`ifdef SERIALIZER_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else if (clear) begin
      cnt <= '0;
    end else if (accept) begin
      shreg    <= in_data;
      cnt      <= '0;
      out_byte <= byte_sel(in_data, 2'd0, MSB);
`ifdef SERIALIZER_PARITY_EN
      out_parity <= ^byte_sel(in_data, 2'd0, MSB);
`endif
    end else if (xfer) begin
      if (at_last) begin
        cnt <= '0;
      end else begin
        cnt      <= cnt + 2'd1;
        out_byte <= byte_sel(shreg, cnt + 2'd1, MSB);
`ifdef SERIALIZER_PARITY_EN
        out_parity <= ^byte_sel(shreg, cnt + 2'd1, MSB);
`endif
      end
    end
  end

endmodule

// File: tb/tb_word_byte_serializer.sv
// tb/tb_word_byte_serializer.sv - scoreboard testbench for word_byte_serializer (both byte orders)
module tb_word_byte_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        out_ready = 1'b1;

  logic       in_ready0, out_valid0, out_last0, busy0;
  logic [7:0] out_byte0;
  logic       in_ready1, out_valid1, out_last1, busy1;
  logic [7:0] out_byte1;
`ifdef SERIALIZER_PARITY_EN
  logic       out_parity0, out_parity1;
`endif

  int checks = 0;
  int errors = 0;

  // Expected byte streams: q0 for LSB-first instance, q1 for MSB-first.
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  word_byte_serializer #(.MSB_FIRST(0), .WORD_W(32)) dut0 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_byte(out_byte0),
    .out_last(out_last0), .busy(busy0)
`ifdef SERIALIZER_PARITY_EN
    , .out_parity(out_parity0)
`endif
  );

  word_byte_serializer #(.MSB_FIRST(1), .WORD_W(32)) dut1 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_byte(out_byte1),
    .out_last(out_last1), .busy(busy1)
`ifdef SERIALIZER_PARITY_EN
    , .out_parity(out_parity1)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a word is taken whenever it is offered and nothing is
  // left to send from the previous word (the monitor has already removed
  // bytes the sink took this cycle). Each word expands to four bytes.
  always @(posedge clk) begin
    if (rst || clear) begin
      q0.delete();
      q1.delete();
    end else if (in_valid && q0.size() == 0) begin
      for (int i = 0; i < 4; i++) begin
        q0.push_back(8'((in_data >> (8 * i)) & 32'hFF));
        q1.push_back(8'((in_data >> (8 * (3 - i))) & 32'hFF));
      end
    end
  end

  // Monitor: compares presented bytes and handshake signals, pops on transfer.
  always @(negedge clk) begin
    logic exp_rdy;
    logic exp_vld;
    if (rst) begin
      chk("rst_out_valid0", 32'(out_valid0), 32'd0);
      chk("rst_out_valid1", 32'(out_valid1), 32'd0);
      chk("rst_busy0", 32'(busy0), 32'd0);
      chk("rst_out_last0", 32'(out_last0), 32'd0);
      chk("rst_out_byte0", 32'(out_byte0), 32'd0);
      chk("rst_out_byte1", 32'(out_byte1), 32'd0);
      chk("rst_in_ready0", 32'(in_ready0), 32'(!clear));
`ifdef SERIALIZER_PARITY_EN
      chk("rst_parity0", 32'(out_parity0), 32'd0);
`endif
      q0.delete();
      q1.delete();
    end else begin
      exp_vld = (q0.size() != 0);
      exp_rdy = !clear && (q0.size() == 0 || (q0.size() == 1 && out_ready));
      chk("in_ready0", 32'(in_ready0), 32'(exp_rdy));
      chk("in_ready1", 32'(in_ready1), 32'(exp_rdy));
      chk("out_valid0", 32'(out_valid0), 32'(exp_vld));
      chk("out_valid1", 32'(out_valid1), 32'(exp_vld));
      chk("busy0", 32'(busy0), 32'(exp_vld));
      chk("busy1", 32'(busy1), 32'(exp_vld));
      if (exp_vld) begin
        chk("out_byte_lsbfirst", 32'(out_byte0), 32'(q0[0]));
        chk("out_byte_msbfirst", 32'(out_byte1), 32'(q1[0]));
        chk("out_last0", 32'(out_last0), 32'(q0.size() == 1));
        chk("out_last1", 32'(out_last1), 32'(q1.size() == 1));
`ifdef SERIALIZER_PARITY_EN
        chk("out_parity0", 32'(out_parity0), 32'(^q0[0]));
        chk("out_parity1", 32'(out_parity1), 32'(^q1[0]));
`endif
        if (out_ready) begin
          void'(q0.pop_front());
          void'(q1.pop_front());
        end
      end else begin
        chk("out_last0_idle", 32'(out_last0), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word and hold it until the (LSB-first) instance takes it.
  task automatic send_word(input logic [31:0] w);
    bit taken = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 40 && !taken; i++) begin
      @(negedge clk);
      if (in_ready0) taken = 1;
      tick();
    end
    chk("send_word_accepted", 32'(taken), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Basic order in both byte orders
    out_ready = 1'b1;
    send_word(32'h11223344);
    repeat (5) tick();
    send_word(32'hDEADBEEF);
    repeat (5) tick();

    // Backpressure: stall while the second byte is presented
    send_word(32'h0A0B0C0D);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h99999999;
    repeat (3) tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();

    // Back-to-back words
    send_word(32'h00000001);
    send_word(32'h00000002);
    repeat (6) tick();

    // Parity pattern
    send_word(32'h0700FF01);
    repeat (5) tick();

    // clear mid-word with a word offered in the same cycle
    send_word(32'hCAFEF00D);
    tick();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h12345678;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    tick();
    send_word(32'h55667788);
    repeat (5) tick();

    // Randomized traffic including stalls, clears and resets
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      clear     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Drain
    rst = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk("drain_empty", 32'(q0.size()), 32'd0);
    chk("drain_idle", 32'(busy0 | busy1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
